// File: rtl/fetch_stage.sv
// Instruction fetch: PC, credit-limited imem requests, in-order response FIFO, registered bundle out.
// Response in cycle M reaches stage_out_insn in M+2; stall holds the output, full credit stops requests.

package core;
   parameter int ADDR_WIDTH = 16;
   parameter int INSN_WIDTH = 32;
   parameter logic [ADDR_WIDTH-1:0] INSN_ADDR_START = 16'h0040;

   typedef struct packed {
      logic                  valid;
      logic [ADDR_WIDTH-1:0] addr;
      logic [INSN_WIDTH-1:0] insn;
   } InsnBundle;
endpackage

module fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       flush,
   input  logic                       push_vld,
   input  logic [W-1:0]               push_dat,
   input  logic                       pop_rdy,
   output logic [W-1:0]               pop_dat,
   output logic [$clog2(DEPTH):0]     count
);
   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;

   always_ff @(posedge clk) begin
      if (push_vld) mem[wr_ptr] <= push_dat;
   end

   always_ff @(posedge clk) begin
      if (!rst || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_vld) wr_ptr <= wr_ptr + AW'(1);
         if (pop_rdy)  rd_ptr <= rd_ptr + AW'(1);
         count <= count + (AW+1)'(push_vld) - (AW+1)'(pop_rdy);
      end
   end

   assign pop_dat = mem[rd_ptr];
endmodule

module fetch_stage #(
   parameter int                    ADDR_WIDTH      = core::ADDR_WIDTH,
   parameter int                    INSN_WIDTH      = core::INSN_WIDTH,
   parameter logic [ADDR_WIDTH-1:0] INSN_ADDR_START = core::INSN_ADDR_START,
   parameter int                    FIFO_DEPTH      = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  stall,
   input  logic                  redirect_valid,
   input  logic [ADDR_WIDTH-1:0] redirect_addr,
   output logic                  imem_req_valid,
   input  logic                  imem_req_ready,
   output logic [ADDR_WIDTH-1:0] imem_req_addr,
   input  logic                  imem_rsp_valid,
   input  logic [INSN_WIDTH-1:0] imem_rsp_data,
   output core::InsnBundle       stage_out_insn
);
   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   logic [ADDR_WIDTH-1:0]            pc;
   logic [CW-1:0]                    outstanding;
   logic [CW-1:0]                    fifo_count;
   logic [CW-1:0]                    drop_cnt;
   logic [CW:0]                      credit_used;
   logic [ADDR_WIDTH-1:0]            rsp_addr;
   logic [ADDR_WIDTH+INSN_WIDTH-1:0] head;
   logic                             fire;
   logic                             rsp_ok;
   logic                             rsp_keep;
   logic                             pop;

   // Outstanding requests plus buffered responses never exceed the FIFO size.
   assign credit_used    = {1'b0, outstanding} + {1'b0, fifo_count};
   assign imem_req_valid = rst && !redirect_valid && (credit_used < (CW+1)'(FIFO_DEPTH));
   assign imem_req_addr  = pc;
   assign fire           = imem_req_valid && imem_req_ready;
   assign rsp_ok         = imem_rsp_valid && (outstanding != '0);
   assign rsp_keep       = rsp_ok && !redirect_valid && (drop_cnt == '0);
   assign pop            = !redirect_valid && !stall && (fifo_count != '0);

   // The address queue depth doubles as the outstanding-request count.
   fifo #(.W(ADDR_WIDTH), .DEPTH(FIFO_DEPTH)) u_addr_q (
      .clk      (clk),
      .rst      (rst),
      .flush    (1'b0),
      .push_vld (fire),
      .push_dat (pc),
      .pop_rdy  (rsp_ok),
      .pop_dat  (rsp_addr),
      .count    (outstanding)
   );

   fifo #(.W(ADDR_WIDTH+INSN_WIDTH), .DEPTH(FIFO_DEPTH)) u_rsp_q (
      .clk      (clk),
      .rst      (rst),
      .flush    (redirect_valid),
      .push_vld (rsp_keep),
      .push_dat ({rsp_addr, imem_rsp_data}),
      .pop_rdy  (pop),
      .pop_dat  (head),
      .count    (fifo_count)
   );

   always_ff @(posedge clk) begin
      if (!rst)                pc <= INSN_ADDR_START;
      else if (redirect_valid) pc <= redirect_addr;
      else if (fire)           pc <= pc + ADDR_WIDTH'(1);
   end

   // After a redirect every request still in flight is stale, including ones already marked.
   always_ff @(posedge clk) begin
      if (!rst)
         drop_cnt <= '0;
      else if (redirect_valid)
         drop_cnt <= outstanding - CW'(rsp_ok);
      else if (rsp_ok && (drop_cnt != '0))
         drop_cnt <= drop_cnt - CW'(1);
   end

   always_ff @(posedge clk) begin
      if (!rst)
         stage_out_insn <= '0;
      else if (redirect_valid)
         stage_out_insn.valid <= 1'b0;
      else if (!stall) begin
         if (fifo_count != '0) stage_out_insn <= {1'b1, head};
         else                  stage_out_insn.valid <= 1'b0;
      end
   end
endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with an in-order instruction memory model of programmable latency.
module tb_fetch_stage;
   localparam int AW = 16;
   localparam int IW = 32;

   logic          clk = 1'b0;
   logic          rst;
   logic          stall;
   logic          redirect_valid;
   logic [AW-1:0] redirect_addr;
   logic          imem_req_valid;
   logic          imem_req_ready;
   logic [AW-1:0] imem_req_addr;
   logic          imem_rsp_valid;
   logic [IW-1:0] imem_rsp_data;
   logic [AW+IW:0] stage_out;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int lat   = 1;
   int            due_q[$];
   logic [AW-1:0] addr_q[$];

   always #5 clk = ~clk;

   fetch_stage dut (
      .clk            (clk),
      .rst            (rst),
      .stall          (stall),
      .redirect_valid (redirect_valid),
      .redirect_addr  (redirect_addr),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_req_addr  (imem_req_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .stage_out_insn (stage_out)
   );

   function automatic logic [IW-1:0] mem_word(input logic [AW-1:0] a);
      return {~a, a};
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic expect_out(input string tag, input logic v, input logic [AW-1:0] a);
      chk({tag, ".valid"}, 64'(stage_out[AW+IW]), 64'(v));
      if (v) begin
         chk({tag, ".addr"}, 64'(stage_out[AW+IW-1:IW]), 64'(a));
         chk({tag, ".insn"}, 64'(stage_out[IW-1:0]), 64'(mem_word(a)));
      end
   endtask

   // One clock: capture the handshake before the edge, then drive the memory response for the new cycle.
   task automatic tick();
      logic          f;
      logic          r;
      logic [AW-1:0] a;
      @(negedge clk);
      f = imem_req_valid && imem_req_ready;
      r = rst;
      a = imem_req_addr;
      @(posedge clk);
      #1;
      if (!r) begin
         due_q.delete();
         addr_q.delete();
      end else if (f) begin
         due_q.push_back(cyc + lat);
         addr_q.push_back(a);
      end
      cyc++;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
      if (r && due_q.size() != 0 && due_q[0] == cyc) begin
         imem_rsp_valid = 1'b1;
         imem_rsp_data  = mem_word(addr_q[0]);
         void'(due_q.pop_front());
         void'(addr_q.pop_front());
      end
   endtask

   initial begin
      rst = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_addr = '0;
      imem_req_ready = 1'b1; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
      repeat (3) tick();
      #1;
      chk("rst_out_valid", 64'(stage_out[AW+IW]), 0);
      chk("rst_req_valid", 64'(imem_req_valid), 0);

      // Streaming from reset, latency 1
      rst = 1'b1; #1;
      chk("t1_req_valid", 64'(imem_req_valid), 1);
      chk("t1_req_addr0", 64'(imem_req_addr), 64'h40);
      expect_out("t1_c0", 1'b0, '0);
      tick(); #1;
      chk("t1_req_addr1", 64'(imem_req_addr), 64'h41);
      expect_out("t1_c1", 1'b0, '0);
      tick(); expect_out("t1_c2", 1'b0, '0);
      tick(); expect_out("t1_c3", 1'b1, 16'h40);
      for (int i = 1; i <= 5; i++) begin
         tick(); expect_out($sformatf("t1_s%0d", i), 1'b1, AW'(16'h40 + i));
      end

      // Stall for six cycles: output holds, buffer fills, requests stop
      stall = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick(); expect_out($sformatf("t3_hold%0d", i), 1'b1, 16'h45);
      end
      #1; chk("t3_req_valid_full", 64'(imem_req_valid), 0);
      stall = 1'b0; #1;
      chk("t3_req_valid_rel", 64'(imem_req_valid), 0);
      for (int i = 0; i < 8; i++) begin
         tick(); expect_out($sformatf("t3_s%0d", i), 1'b1, AW'(16'h46 + i));
      end

      // Drain with ready low
      imem_req_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick(); expect_out($sformatf("dr_s%0d", i), 1'b1, AW'(16'h4E + i));
      end
      tick(); expect_out("dr_empty", 1'b0, '0);
      #1;
      chk("dr_req_valid", 64'(imem_req_valid), 1);
      chk("dr_req_addr", 64'(imem_req_addr), 64'h51);

      // Latency 3, redirect with three outstanding and one buffered
      lat = 3; imem_req_ready = 1'b1;
      repeat (4) tick();
      expect_out("t4_p4", 1'b0, '0);
      redirect_valid = 1'b1; redirect_addr = 16'h0200; #1;
      chk("t4_req_valid_redir", 64'(imem_req_valid), 0);
      tick();
      redirect_valid = 1'b0; #1;
      chk("t4_req_addr", 64'(imem_req_addr), 64'h200);
      expect_out("t4_p5", 1'b0, '0);
      for (int i = 6; i <= 9; i++) begin
         tick(); expect_out($sformatf("t4_p%0d", i), 1'b0, '0);
      end
      for (int i = 0; i < 4; i++) begin
         tick(); expect_out($sformatf("t4_new%0d", i), 1'b1, AW'(16'h200 + i));
      end
      imem_req_ready = 1'b0;
      tick(); expect_out("t4_gap", 1'b0, '0);
      for (int i = 0; i < 3; i++) begin
         tick(); expect_out($sformatf("t4_tail%0d", i), 1'b1, AW'(16'h204 + i));
      end
      tick(); expect_out("t4_empty", 1'b0, '0);
      #1; chk("t4_req_addr_end", 64'(imem_req_addr), 64'h207);

      // Redirect with stall and a response in the same cycle
      lat = 1; imem_req_ready = 1'b1;
      tick(); expect_out("t5_q1", 1'b0, '0);
      tick(); expect_out("t5_q2", 1'b0, '0);
      tick(); expect_out("t5_q3", 1'b1, 16'h207);
      stall = 1'b1; redirect_valid = 1'b1; redirect_addr = 16'h0300;
      tick(); expect_out("t5_q4", 1'b0, '0);
      stall = 1'b0; redirect_valid = 1'b0; #1;
      chk("t5_req_addr", 64'(imem_req_addr), 64'h300);
      tick(); expect_out("t5_q5", 1'b0, '0);
      tick(); expect_out("t5_q6", 1'b0, '0);
      for (int i = 0; i < 3; i++) begin
         tick(); expect_out($sformatf("t5_s%0d", i), 1'b1, AW'(16'h300 + i));
      end

      // Reset mid-stream with two requests in flight
      lat = 2;
      tick(); tick();
      rst = 1'b0;
      tick(); expect_out("t6_rst", 1'b0, '0);
      #1; chk("t6_req_valid_rst", 64'(imem_req_valid), 0);
      rst = 1'b1; #1;
      chk("t6_req_valid", 64'(imem_req_valid), 1);
      chk("t6_req_addr", 64'(imem_req_addr), 64'h40);

      // Ready held low for ten cycles after reset
      lat = 1; imem_req_ready = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick(); #1;
         chk($sformatf("t2_req_valid%0d", i), 64'(imem_req_valid), 1);
         chk($sformatf("t2_req_addr%0d", i), 64'(imem_req_addr), 64'h40);
         expect_out($sformatf("t2_idle%0d", i), 1'b0, '0);
      end
      imem_req_ready = 1'b1;
      tick(); expect_out("t2_r11", 1'b0, '0);
      tick(); expect_out("t2_r12", 1'b0, '0);
      for (int i = 0; i < 4; i++) begin
         tick(); expect_out($sformatf("t2_s%0d", i), 1'b1, AW'(16'h40 + i));
      end

      // PC wrap at the top of the address space
      redirect_valid = 1'b1; redirect_addr = 16'hFFFF;
      tick();
      redirect_valid = 1'b0; #1;
      chk("wr_req_addr_top", 64'(imem_req_addr), 64'hFFFF);
      expect_out("wr_s1", 1'b0, '0);
      tick(); #1;
      chk("wr_req_addr_wrap", 64'(imem_req_addr), 64'h0000);
      expect_out("wr_s2", 1'b0, '0);
      tick(); expect_out("wr_s3", 1'b0, '0);
      tick(); expect_out("wr_s4", 1'b1, 16'hFFFF);
      tick(); expect_out("wr_s5", 1'b1, 16'h0000);
      tick(); expect_out("wr_s6", 1'b1, 16'h0001);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
